mem_arb_emulator: RTL and testbench

MEM_ARB_EMULATOR -- requirements
Module: mem_arb_emulator

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/mem_rd_pipe.sv | 56 +++++
 rtl/mem_arb_emulator.sv | 136 +++++++++++++
 tb/tb_mem_arb_emulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and default constants for mem_arb_emulator
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_WIDTH  = 128;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_SIZE   = 256;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_CNT_W  = 16;

    // Struct fields are sized for the largest supported configuration;
    // instances zero-extend their narrower ports into them.
    localparam int MAX_WIDTH  = 1024;
    localparam int MAX_LANES  = 128;
    localparam int MAX_ADDR_W = 32;

    typedef struct packed {
        logic                  cenb;
        logic                  wenb;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_LANES-1:0]  lane_en;
        logic [MAX_WIDTH-1:0]  data;
    } mem_req_t;

    typedef struct packed {
        logic                 valid;
        logic                 src;
        logic [MAX_WIDTH-1:0] data;
    } rd_stage_t;

endpackage

`default_nettype wire

// File: rtl/mem_rd_pipe.sv
// ============================================================================
// mem_rd_pipe : RD_LAT-stage read-return pipeline; data/src hold when idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rd_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_async_i,
    input  rd_stage_t        in_stage,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o,
    output logic             q_src_o
);

    generate
        for (genvar i = 0; i < RD_LAT; i++) begin : g_stage
            rd_stage_t prev;
            rd_stage_t stage;

            if (i == 0) begin : g_head
                assign prev = in_stage;
            end else begin : g_link
                assign prev = g_stage[i-1].stage;
            end

            // Payload only advances with a valid beat so the last stage holds q.
            always_ff @(posedge clk_i or posedge rst_async_i) begin
                if (rst_async_i) begin
                    stage <= '0;
                end else begin
                    stage.valid <= prev.valid;
                    if (prev.valid) begin
                        stage.src  <= prev.src;
                        stage.data <= prev.data;
                    end
                end
            end
        end
    endgenerate

    assign q_o       = g_stage[RD_LAT-1].stage.data[WIDTH-1:0];
    assign q_valid_o = g_stage[RD_LAT-1].stage.valid;
    assign q_src_o   = g_stage[RD_LAT-1].stage.src;

    logic unused_data;
    assign unused_data = ^g_stage[RD_LAT-1].stage.data;

endmodule

`default_nettype wire

// File: rtl/mem_arb_emulator.sv
// ============================================================================
// mem_arb_emulator : single-port lane-writable memory, ext-priority arbiter,
//                    pipelined reads and saturating access statistics
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_emulator
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANE_W = DEF_LANE_W,
    parameter int SIZE   = DEF_SIZE,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_async_i,
    input  logic                      ext_cenb_i,
    input  logic                      ext_wenb_i,
    input  logic [$clog2(SIZE)-1:0]   ext_addr_i,
    input  logic [WIDTH/LANE_W-1:0]   ext_lane_en_i,
    input  logic [WIDTH-1:0]          ext_d_i,
    input  logic                      core_cenb_i,
    input  logic                      core_wenb_i,
    input  logic [$clog2(SIZE)-1:0]   core_addr_i,
    input  logic [WIDTH/LANE_W-1:0]   core_lane_en_i,
    input  logic [WIDTH-1:0]          core_d_i,
    output logic                      core_gnt_o,
    output logic [WIDTH-1:0]          q_o,
    output logic                      q_valid_o,
    output logic                      q_src_o,
    input  logic                      clr_cnt_i,
    output logic [CNT_W-1:0]          rd_cnt_o,
    output logic [CNT_W-1:0]          wr_cnt_o,
    output logic [CNT_W-1:0]          conflict_cnt_o
);

    localparam int             LANES   = WIDTH / LANE_W;
    localparam int             ADDR_W  = $clog2(SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mem_req_t          ext_req;
    mem_req_t          core_req;
    mem_req_t          sel_req;
    logic              ext_act;
    logic              core_act;
    logic              in_range;
    logic              rd_acc;
    logic              wr_acc;
    logic              both_req;
    logic [ADDR_W-1:0] idx;
    logic [WIDTH-1:0]  rd_word;
    rd_stage_t         pipe_in;
    logic [WIDTH-1:0]  mem [SIZE];

    always_comb begin
        ext_req  = '{cenb: ext_cenb_i, wenb: ext_wenb_i,
                     addr: MAX_ADDR_W'(ext_addr_i),
                     lane_en: MAX_LANES'(ext_lane_en_i),
                     data: MAX_WIDTH'(ext_d_i)};
        core_req = '{cenb: core_cenb_i, wenb: core_wenb_i,
                     addr: MAX_ADDR_W'(core_addr_i),
                     lane_en: MAX_LANES'(core_lane_en_i),
                     data: MAX_WIDTH'(core_d_i)};

        ext_act  = !rst_async_i && !ext_req.cenb;
        core_act = !rst_async_i && !core_req.cenb && ext_req.cenb;
        sel_req  = ext_act ? ext_req : core_req;
        both_req = !ext_cenb_i && !core_cenb_i;

        in_range = sel_req.addr < MAX_ADDR_W'(SIZE);
        idx      = sel_req.addr[ADDR_W-1:0];
        rd_acc   = (ext_act || core_act) && sel_req.wenb;
        wr_acc   = (ext_act || core_act) && !sel_req.wenb;

        rd_word  = '0;
        if (in_range) begin
            rd_word = mem[idx];
        end
        pipe_in  = '{valid: rd_acc, src: ext_act, data: MAX_WIDTH'(rd_word)};
    end

    assign core_gnt_o = core_act;

    logic unused_req;
    assign unused_req = ^{sel_req.cenb, sel_req.lane_en, sel_req.data};

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc && in_range) begin
            for (int l = 0; l < LANES; l++) begin
                if (sel_req.lane_en[l]) begin
                    mem[idx][l*LANE_W +: LANE_W] <= sel_req.data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            rd_cnt_o       <= '0;
            wr_cnt_o       <= '0;
            conflict_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            rd_cnt_o       <= '0;
            wr_cnt_o       <= '0;
            conflict_cnt_o <= '0;
        end else begin
            if (rd_acc && rd_cnt_o != CNT_MAX) begin
                rd_cnt_o <= rd_cnt_o + 1'b1;
            end
            if (wr_acc && wr_cnt_o != CNT_MAX) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
            if (both_req && conflict_cnt_o != CNT_MAX) begin
                conflict_cnt_o <= conflict_cnt_o + 1'b1;
            end
        end
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .WIDTH  (WIDTH)
    ) u_rd_pipe (
        .clk_i       (clk_i),
        .rst_async_i (rst_async_i),
        .in_stage    (pipe_in),
        .q_o         (q_o),
        .q_valid_o   (q_valid_o),
        .q_src_o     (q_src_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_arb_emulator.sv
// ============================================================================
// tb_mem_arb_emulator : directed bench with queue-based reference model
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arb_emulator;

    localparam int W    = 32;
    localparam int LW   = 8;
    localparam int SZ   = 12;
    localparam int RL   = 3;
    localparam int CW   = 4;
    localparam int AW   = $clog2(SZ);
    localparam int NL   = W / LW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ext_cenb, ext_wenb, core_cenb, core_wenb, clr;
    logic [AW-1:0] ext_addr, core_addr;
    logic [NL-1:0] ext_lane, core_lane;
    logic [W-1:0]  ext_d, core_d;
    logic          core_gnt, q_valid, q_src;
    logic [W-1:0]  q;
    logic [CW-1:0] rd_cnt, wr_cnt, cf_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arb_emulator #(
        .WIDTH(W), .LANE_W(LW), .SIZE(SZ), .RD_LAT(RL), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_async_i(rst),
        .ext_cenb_i(ext_cenb), .ext_wenb_i(ext_wenb), .ext_addr_i(ext_addr),
        .ext_lane_en_i(ext_lane), .ext_d_i(ext_d),
        .core_cenb_i(core_cenb), .core_wenb_i(core_wenb), .core_addr_i(core_addr),
        .core_lane_en_i(core_lane), .core_d_i(core_d),
        .core_gnt_o(core_gnt), .q_o(q), .q_valid_o(q_valid), .q_src_o(q_src),
        .clr_cnt_i(clr), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .conflict_cnt_o(cf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected read returns are queued with the cycle they are due.
    typedef struct {
        int           due;
        logic [W-1:0] data;
        logic         src;
    } pend_t;

    pend_t        pend[$];
    logic [W-1:0] mm [SZ];
    int           cyc = 0;
    logic [W-1:0] e_q = '0;
    logic         e_v = 1'b0;
    logic         e_src = 1'b0;
    int           e_rd = 0, e_wr = 0, e_cf = 0;
    logic         m_ext, m_core, m_wr;
    int           m_a;
    logic [NL-1:0] m_lane;
    logic [W-1:0] m_d, m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            e_q = '0; e_v = 1'b0; e_src = 1'b0;
            e_rd = 0; e_wr = 0; e_cf = 0;
        end else begin
            cyc++;
            m_ext  = !ext_cenb;
            m_core = !core_cenb && ext_cenb;
            if (m_ext || m_core) begin
                m_a    = m_ext ? int'(ext_addr) : int'(core_addr);
                m_wr   = m_ext ? !ext_wenb : !core_wenb;
                m_lane = m_ext ? ext_lane : core_lane;
                m_d    = m_ext ? ext_d : core_d;
                if (m_wr) begin
                    if (m_a < SZ) begin
                        for (int l = 0; l < NL; l++) begin
                            if (m_lane[l]) mm[m_a][l*LW +: LW] = m_d[l*LW +: LW];
                        end
                    end
                    e_wr = (e_wr < CMAX) ? e_wr + 1 : CMAX;
                end else begin
                    m_rd = '0;
                    if (m_a < SZ) m_rd = mm[m_a];
                    pend.push_back('{due: cyc + RL - 1, data: m_rd, src: m_ext});
                    e_rd = (e_rd < CMAX) ? e_rd + 1 : CMAX;
                end
            end
            if (!ext_cenb && !core_cenb) e_cf = (e_cf < CMAX) ? e_cf + 1 : CMAX;
            if (clr) begin
                e_rd = 0; e_wr = 0; e_cf = 0;
            end
            e_v = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_v   = 1'b1;
                e_q   = pend[0].data;
                e_src = pend[0].src;
                void'(pend.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("core_gnt", W'(core_gnt), W'(!rst && !core_cenb && ext_cenb));
        check("q_valid", W'(q_valid), W'(e_v));
        check("q_src", W'(q_src), W'(e_src));
        check("q", q, e_q);
        check("rd_cnt", W'(rd_cnt), W'(e_rd));
        check("wr_cnt", W'(wr_cnt), W'(e_wr));
        check("conflict_cnt", W'(cf_cnt), W'(e_cf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ext_cenb = 1'b1; ext_wenb = 1'b1; ext_addr = '0; ext_lane = '0; ext_d = '0;
        core_cenb = 1'b1; core_wenb = 1'b1; core_addr = '0; core_lane = '0; core_d = '0;
        clr = 1'b0;
    endtask

    task automatic ext_op(input logic wr, input int a, input logic [NL-1:0] ln, input logic [W-1:0] d);
        ext_cenb = 1'b0; ext_wenb = !wr; ext_addr = AW'(a); ext_lane = ln; ext_d = d;
        tick();
        idle();
    endtask

    task automatic core_op(input logic wr, input int a, input logic [NL-1:0] ln, input logic [W-1:0] d);
        core_cenb = 1'b0; core_wenb = !wr; core_addr = AW'(a); core_lane = ln; core_d = d;
        tick();
        idle();
    endtask

    task automatic clear_cnt();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int a = 0; a < SZ; a++) ext_op(1'b1, a, '1, 32'hA000_0000 | W'(a << 8) | W'(a));
        clear_cnt();

        // Lane-selective write then readback
        ext_op(1'b1, 3, '1, 32'hFFFF_FFFF);
        ext_op(1'b1, 3, 4'b0001, 32'h0000_0000);
        core_op(1'b0, 3, '0, '0);
        check("lane_early0", W'(q_valid), 32'd0);
        tick();
        check("lane_early1", W'(q_valid), 32'd0);
        tick();
        check("lane_valid", W'(q_valid), 32'd1);
        check("lane_q", q, 32'hFFFF_FF00);

        // Read-after-write, consecutive cycles
        ext_op(1'b1, 4, '1, 32'h1234_5678);
        core_op(1'b0, 4, '0, '0);
        repeat (2) tick();
        check("raw_q", q, 32'h1234_5678);

        // Conflict: ext read 5 against core write 7
        clear_cnt();
        ext_cenb = 1'b0; ext_wenb = 1'b1; ext_addr = AW'(5);
        core_cenb = 1'b0; core_wenb = 1'b0; core_addr = AW'(7); core_lane = '1; core_d = 32'hDEAD_BEEF;
        #1 check("conflict_gnt", W'(core_gnt), 32'd0);
        tick();
        idle();
        check("conflict_cnt_lit", W'(cf_cnt), 32'd1);
        repeat (2) tick();
        check("conflict_src", W'(q_src), 32'd1);
        check("conflict_q", q, 32'hA000_0505);
        core_op(1'b0, 7, '0, '0);
        repeat (2) tick();
        check("addr7_kept", q, 32'hA000_0707);

        // Streaming reads 0..7
        clear_cnt();
        for (int a = 0; a < 8; a++) core_op(1'b0, a, '0, '0);
        repeat (RL) tick();
        check("stream_rd_cnt", W'(rd_cnt), 32'd8);

        // Reset one cycle after an accepted read; core request held during reset
        core_op(1'b0, 2, '0, '0);
        rst = 1'b1;
        core_cenb = 1'b0;
        #1 check("gnt_in_reset", W'(core_gnt), 32'd0);
        repeat (2) tick();
        idle();
        rst = 1'b0;
        repeat (4) tick();
        check("rst_rd_cnt", W'(rd_cnt), 32'd0);
        check("rst_q_valid", W'(q_valid), 32'd0);

        // Saturation and clear-wins
        for (int i = 0; i < 20; i++) ext_op(1'b1, 9, '1, W'(i));
        check("sat_wr_cnt", W'(wr_cnt), 32'd15);
        clr = 1'b1;
        ext_op(1'b1, 9, '1, 32'h0909_0909);
        check("clr_wins", W'(wr_cnt), 32'd0);

        // Out-of-range read and writes
        core_op(1'b0, 1, '0, '0);
        repeat (2) tick();
        core_op(1'b0, SZ, '0, '0);
        repeat (2) tick();
        check("oor_valid", W'(q_valid), 32'd1);
        check("oor_q", q, 32'd0);
        ext_op(1'b1, SZ, '1, 32'hFFFF_FFFF);
        core_op(1'b1, 15, '1, 32'hFFFF_FFFF);
        for (int a = 0; a < SZ; a++) ext_op(1'b0, a, '0, '0);
        repeat (RL + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
